// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wport_arbiter: round-robin arbiter for the register file write     |
// | port, with a zeroing sweep. Optional read bypass: RF_BYPASS_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_wport_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int GW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [WIDTH-1:0]      rf_wdata,
  output logic [GW-1:0]         grant_id,
  input  logic [AW-1:0]         rd_addr1,
  input  logic [AW-1:0]         rd_addr2,
  input  logic [WIDTH-1:0]      rf_rdata1,
  input  logic [WIDTH-1:0]      rf_rdata2,
  output logic [WIDTH-1:0]      rd_data1,
  output logic [WIDTH-1:0]      rd_data2
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   rr_ptr;
  logic            grant_vld;
  logic [GW-1:0]   grant_idx;
  logic [NREQ-1:0] ready_vec;
  logic            sweep_last;

  assign sweep_last = (rf_waddr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    int j;
    state_next = state;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    ready_vec  = '0;
    j          = 0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else begin
          // Scan upward from the pointer, wrapping at NREQ; first valid wins.
          for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_vld && req_valid[j]) begin
              grant_vld = 1'b1;
              grant_idx = GW'(j);
            end
          end
        end
      end
      CLEAR: begin
        if (sweep_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (grant_vld) ready_vec[grant_idx] = 1'b1;
  end

  assign req_ready  = rst_n ? ready_vec : '0;
  assign clear_busy = (state == CLEAR);

  // The write port registers double as the sweep counter while in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= '0;
            rf_wdata <= '0;
          end else if (grant_vld) begin
            rf_we    <= 1'b1;
            rf_waddr <= req_addr[grant_idx*AW +: AW];
            rf_wdata <= req_data[grant_idx*WIDTH +: WIDTH];
            grant_id <= grant_idx;
            rr_ptr   <= (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          end else begin
            rf_we <= 1'b0;
          end
        end
        CLEAR: begin
          if (sweep_last) begin
            rf_we <= 1'b0;
          end else begin
            rf_we    <= 1'b1;
            rf_waddr <= rf_waddr + 1'b1;
          end
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

`ifdef RF_BYPASS_EN
  // Forward the write that commits at the next edge.
  assign rd_data1 = (rf_we && (rf_waddr == rd_addr1)) ? rf_wdata : rf_rdata1;
  assign rd_data2 = (rf_we && (rf_waddr == rd_addr2)) ? rf_wdata : rf_rdata2;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign rd_data1       = rf_rdata1;
  assign rd_data2       = rf_rdata2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// Randomized and directed checks of regfile_wport_arbiter against a behavioural model.
module tb_regfile_wport_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NREQ  = 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int GW    = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [WIDTH-1:0]      rf_wdata;
  logic [GW-1:0]         grant_id;
  logic [AW-1:0]         rd_addr1, rd_addr2;
  logic [WIDTH-1:0]      rf_rdata1, rf_rdata2;
  logic [WIDTH-1:0]      rd_data1, rd_data2;

  regfile_wport_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pointer, sweep progress and the expected write port.
  int              m_ptr;
  int              m_left;
  int              m_idx;
  logic            m_we;
  logic [AW-1:0]   m_waddr;
  logic [WIDTH-1:0] m_wdata;
  logic [GW-1:0]   m_gid;
  logic [NREQ-1:0] last_grant;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_left = 0; m_idx = 0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = '0;
    last_grant = '0;
  endtask

  function automatic int pick();
    if (!rst_n || m_left > 0 || clear_req) return -1;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] ra, input logic [WIDTH-1:0] raw);
`ifdef RF_BYPASS_EN
    if (m_we && m_waddr == ra) return m_wdata;
`endif
    return raw;
  endfunction

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic step();
    int k;
    logic [NREQ-1:0] er;
    rd_addr1  = AW'($urandom);
    rd_addr2  = AW'($urandom);
    rf_rdata1 = WIDTH'($urandom);
    rf_rdata2 = WIDTH'($urandom);
    #1;
    k  = pick();
    er = '0;
    if (k >= 0) er[k] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(er));
    check_eq("rf_we", 32'(rf_we), 32'(m_we));
    check_eq("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    check_eq("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
    check_eq("grant_id", 32'(grant_id), 32'(m_gid));
    check_eq("clear_busy", 32'(clear_busy), 32'(m_left > 0));
    check_eq("rd_data1", 32'(rd_data1), 32'(exp_rd(rd_addr1, rf_rdata1)));
    check_eq("rd_data2", 32'(rd_data2), 32'(exp_rd(rd_addr2, rf_rdata2)));
    last_grant = er;
    if (m_left > 0) begin
      m_left--; m_idx++;
      if (m_left == 0) m_we = 1'b0;
      else begin m_we = 1'b1; m_waddr = AW'(m_idx); m_wdata = '0; end
    end else if (clear_req) begin
      m_left = DEPTH; m_idx = 0;
      m_we = 1'b1; m_waddr = '0; m_wdata = '0;
    end else if (k >= 0) begin
      m_we = 1'b1;
      m_waddr = req_addr[k*AW +: AW];
      m_wdata = req_data[k*WIDTH +: WIDTH];
      m_gid = GW'(k);
      m_ptr = (k + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_payload(input int i);
    req_addr[i*AW +: AW]       = AW'($urandom);
    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // Requesters hold valid/addr/data until granted.
  task automatic new_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (last_grant[i]) begin
        req_valid[i] = 1'($urandom_range(0, 1));
        new_payload(i);
      end else if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
        req_valid[i] = 1'b1;
        new_payload(i);
      end
    end
    clear_req = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '1; req_addr = '0; req_data = '0; clear_req = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rf_we", 32'(rf_we), 32'h0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'h0);
    check_eq("rst_wdata", 32'(rf_wdata), 32'h0);
    check_eq("rst_gid", 32'(grant_id), 32'h0);
    check_eq("rst_busy", 32'(clear_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All three requesters held valid: strict 0,1,2,0,1,2 rotation.
    for (int i = 0; i < NREQ; i++) new_payload(i);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("rr_order", 32'(last_grant), 32'(1 << (c % NREQ)));
      for (int i = 0; i < NREQ; i++) if (last_grant[i]) new_payload(i);
    end
    req_valid = '0;
    step();

    // Lone requester 1, addr 2, data A5; pointer then favours requester 2.
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 2'd2;
    req_data[1*WIDTH +: WIDTH] = 8'hA5;
    step();
    check_eq("lone_grant", 32'(last_grant), 32'b010);
    req_valid = '0;
    step();
    req_valid = 3'b111;
    step();
    check_eq("ptr_after_1", 32'(last_grant), 32'b100);

    // Clear beats a pending request; a re-pulse mid-sweep is ignored.
    req_valid = 3'b001;
    clear_req = 1'b1;
    step();
    check_eq("clear_prio", 32'(last_grant), 32'b000);
    clear_req = 1'b0; step();
    clear_req = 1'b1; step();
    clear_req = 1'b0; step();
    step();
    step();
    check_eq("post_sweep_grant", 32'(last_grant), 32'b001);

    // Reset during the third sweep cycle aborts the sweep and the pointer.
    req_valid = '0;
    clear_req = 1'b1; step();
    clear_req = 1'b0; step(); step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_we", 32'(rf_we), 32'h0);
    check_eq("abort_busy", 32'(clear_busy), 32'h0);
    check_eq("abort_waddr", 32'(rf_waddr), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    req_valid = 3'b111;
    step();
    check_eq("ptr_after_rst", 32'(last_grant), 32'b001);

    // Randomized traffic with occasional clear pulses.
    for (int c = 0; c < 600; c++) begin
      new_reqs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single write port of the 4 x 8-bit register file between NREQ requesters (ALU writeback, load unit, move/immediate path).
- Uses round-robin arbitration with a valid/ready handshake and registers the winning write onto the register file write port.
- Contains a clear sequencer that zeroes every register without asserting reset.
- Sits between the execute/writeback stage and the register file; read-port bypass is optional.

Parameters:
- WIDTH, 8, data width of a register.
- DEPTH, 4, number of registers; AW = $clog2(DEPTH).
- NREQ, 3, number of write requesters (2..8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester grant; a transfer occurs when valid and ready are both high on a rising edge.
- req_addr  input  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- clear_req  input  1  single-cycle pulse that starts a zeroing sweep.
- clear_busy  output  1  high while the sweep runs.
- rf_we  output  1  register file write enable (registered).
- rf_waddr  output  AW  register file write address (registered).
- rf_wdata  output  WIDTH  register file write data (registered).
- grant_id  output  $clog2(NREQ)  index of the requester whose write is currently on rf_* (registered).
- rd_addr1, rd_addr2  input  AW  register file read addresses (used only with bypass).
- rf_rdata1, rf_rdata2  input  WIDTH  raw register file read data.
- rd_data1, rd_data2  output  WIDTH  read data delivered to the datapath.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - RR pointer = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, grant_id = 0.
  - clear_busy = 0.
  - req_ready is combinationally 0 while reset is asserted.
- States: IDLE and CLEAR.
- IDLE arbitration:
  - Combinational.
  - Search starts at the RR pointer and moves upward modulo NREQ.
  - The first index with req_valid high receives req_ready = 1.
  - req_ready is one-hot or all zero.
- On a transfer from requester k:
  - Next cycle: rf_we = 1, rf_waddr = req_addr[k], rf_wdata = req_data[k], grant_id = k.
  - The RR pointer becomes (k+1) mod NREQ.
  - Latency from request to rf_we is one cycle.
  - Sustained throughput is one write per cycle.
- If no transfer occurs, rf_we = 0 the next cycle. rf_waddr, rf_wdata and grant_id hold their values.
- Requester rule: once req_valid is asserted, it and its addr/data stay stable until the transfer. The arbiter does not check this.
- Entering CLEAR:
  - clear_req high in IDLE takes priority over all requests; every req_ready is 0 that cycle.
  - The next state is CLEAR.
- In CLEAR:
  - clear_busy = 1 and all req_ready = 0.
  - Over DEPTH consecutive cycles: rf_we = 1, rf_wdata = 0, rf_waddr = 0, 1, ..., DEPTH-1.
  - grant_id holds its value during the sweep.
  - After address DEPTH-1 is issued, the next state is IDLE and clear_busy returns to 0.
  - The RR pointer is unchanged by the sweep.
- clear_req asserted while in CLEAR is ignored; the sweep is not restarted.
- Reset asserted mid-sweep aborts it immediately and all outputs return to their reset values.
- A write issued in the cycle before clear_req is accepted still appears on rf_* before the sweep starts.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - rd_dataN = rf_wdata when rf_we = 1 and rf_waddr == rd_addrN; otherwise rd_dataN = rf_rdataN.
  - Both read ports are handled independently.
  - This forwards the write that commits at the next edge.
- Undefined:
  - rd_dataN = rf_rdataN as a pure pass-through.
  - rd_addrN is unused.

Test Plan:
- After reset, req_valid=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2; rf_we high for 6 consecutive cycles starting one cycle after the first grant; grant_id follows the same order.
- Only requester 1 valid, addr=2, data=8'hA5 -> req_ready=3'b010; next cycle rf_we=1, rf_waddr=2, rf_wdata=8'hA5, grant_id=1; RR pointer = 2.
- clear_req and req_valid[0] high in the same IDLE cycle -> req_ready=0; clear_busy high for 4 cycles; rf_waddr 0,1,2,3 with rf_wdata=0; requester 0 is granted in the first IDLE cycle after the sweep.
- rst_n pulsed low during the 3rd sweep cycle -> rf_we=0 and clear_busy=0 immediately; state IDLE; RR pointer=0.
- clear_req re-pulsed during a sweep -> exactly 4 sweep writes occur, not restarted.
- RF_BYPASS_EN defined: rf_we=1, rf_waddr=1, rf_wdata=8'h3C, rd_addr1=1, rd_addr2=0, rf_rdata1=8'h00 -> rd_data1=8'h3C, rd_data2=rf_rdata2. With the macro undefined -> rd_data1=8'h00.
